// File: rtl/fsk_bit_serializer_pkg.sv
// Shared types and constants for the FSK byte-to-bit serializer.
// Optional feature macro: FSK_SER_PARITY_EN (even-parity bit after data bit 7).
package fsk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } fsk_state_e;

    localparam int   FSK_DATA_BITS  = 8;
    localparam logic FSK_IDLE_LEVEL = 1'b1;

`ifdef FSK_SER_PARITY_EN
    localparam bit FSK_PARITY_EN = 1'b1;
`else
    localparam bit FSK_PARITY_EN = 1'b0;
`endif

    // Total clock cycles from the first start-bit cycle to the last stop-bit cycle.
    function automatic int fsk_frame_len(input int baud_div, input int stop_bits, input bit parity_en);
        return (10 + int'(parity_en) + stop_bits - 1) * baud_div;
    endfunction

endpackage

// File: rtl/fsk_bit_serializer_if.sv
// Byte-in / bit-out bundle between a byte source and the serializer.
// master: byte source side; slave: serializer side.
interface fsk_bit_serializer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       bit_data;
    logic       bit_strobe;
    logic       busy;
    logic       frame_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, bit_data, bit_strobe, busy, frame_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, bit_data, bit_strobe, busy, frame_done
    );
endinterface

// File: rtl/fsk_bit_serializer_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1, ticks on the terminal count and
// wraps; a synchronous clear holds it at zero so a new frame starts aligned.
module fsk_baud_tick #(
    parameter int BAUD_DIV = 64
) (
    input  logic clk_in1,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(BAUD_DIV - 1);

    logic [CW-1:0] baud_cnt;

    assign tick = !clr && (baud_cnt == TC);

    // Free-running count within a bit, restarting at every bit boundary.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (clr || tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/fsk_bit_serializer.sv
// UART-style framer feeding the FSK modulator's bit_data input.
// Frame: start 0, 8 data bits LSB first, [even parity], STOP_BITS x 1.
// Optional feature macro: FSK_SER_PARITY_EN.
//
//   state  | meaning
//   IDLE   | line at mark, waiting for a held byte
//   START  | start bit (0)
//   DATA   | data bits, shift[0] on the line
//   PARITY | even-parity bit (only with FSK_SER_PARITY_EN)
//   STOP   | stop bit(s) (1), may chain straight into START
module fsk_bit_serializer
    import fsk_pkg::*;
#(
    parameter int BAUD_DIV  = 64,
    parameter int STOP_BITS = 1
) (
    input  logic                  clk_in1,
    input  logic                  rst_n,
    fsk_bit_serializer_if.slave   ser
);
    localparam logic [2:0] LAST_BIT  = 3'(FSK_DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    fsk_state_e state_q, state_d;
    logic       hold_full_q;
    logic [7:0] hold_data_q;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       bit_q, level_d;
    logic       strobe_q;
    logic       load;
    logic       done;
    logic       tick;
    logic       handshake;
`ifdef FSK_SER_PARITY_EN
    logic       par_q;
`endif

    assign handshake      = ser.in_valid && !hold_full_q;
    assign ser.in_ready   = !hold_full_q;
    assign ser.bit_data   = bit_q;
    assign ser.bit_strobe = strobe_q;
    assign ser.busy       = (state_q != IDLE);
    assign ser.frame_done = done;

    fsk_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk_in1 (clk_in1),
        .rst_n   (rst_n),
        .clr     (state_q == IDLE),
        .tick    (tick)
    );

    // Skid register: a handshake fills it, a load into the shifter empties it.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else if (handshake) begin
            hold_full_q <= 1'b1;
            hold_data_q <= ser.in_data;
        end else if (load) begin
            hold_full_q <= 1'b0;
        end
    end

    // Frame sequencing; a finished frame chains into START when a byte is waiting.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        load       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
`ifdef FSK_SER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d    = STOP;
                        stop_idx_d = 1'b0;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef FSK_SER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done = 1'b1;
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            shift_d = hold_data_q;
        end
    end

    // Line level for the coming cycle, so bit_data is a clean register output.
    always_comb begin
        level_d = FSK_IDLE_LEVEL;
        case (state_d)
            START:  level_d = 1'b0;
            DATA:   level_d = shift_d[0];
`ifdef FSK_SER_PARITY_EN
            PARITY: level_d = par_q;
`endif
            default: level_d = FSK_IDLE_LEVEL;
        endcase
    end

    // State, shifter and registered line outputs.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            bit_q      <= FSK_IDLE_LEVEL;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            bit_q      <= level_d;
            strobe_q   <= load || (tick && (state_d != IDLE));
        end
    end

`ifdef FSK_SER_PARITY_EN
    // Parity is captured from the byte as it enters the shifter.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^hold_data_q;
        end
    end
`endif
endmodule
